// File: rtl/apb_slave_regfile.sv
// APB completer with a 2**ADDR_W x DATA_W register file.
// The top register is a read-only ID. Each access gets WAIT_CYCLES wait states.
// Ports:
//   pclk, presetn         : clock, async active-low reset
//   psel, penable         : APB select and access phase
//   paddr, pwrite, pwdata : setup-phase address, direction, write data
//   pready, prdata        : registered completion and read data
//   pslverr               : registered error (write to the ID register)
module apb_slave_regfile #(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 4,
  parameter int                WAIT_CYCLES = 1,
  parameter logic [DATA_W-1:0] ID_VAL      = 16'hA5C3
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic [ADDR_W-1:0] paddr,
  input  logic              pwrite,
  input  logic [DATA_W-1:0] pwdata,
  output logic              pready,
  output logic [DATA_W-1:0] prdata,
  output logic              pslverr
);

  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] TOP = {ADDR_W{1'b1}};
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]        state, nxt;
  logic [3:0]        cnt, cnt_n;
  logic [ADDR_W-1:0] cap_addr;
  logic              cap_wr;
  logic [DATA_W-1:0] cap_data;
  logic [DATA_W-1:0] regs [NREG];

  logic              setup_hit;
  logic              cap_en;
  logic              commit;
  logic [ADDR_W-1:0] e_addr;
  logic              e_wr;
  logic [DATA_W-1:0] rd_val;
  logic              to_resp;

  assign setup_hit = psel & ~penable;

  // SETUP is the first access cycle. cnt holds the wait states still
  // owed, so RESP lands in access cycle WAIT_CYCLES+1.
  always_comb begin
    nxt    = state;
    cnt_n  = cnt;
    cap_en = 1'b0;
    unique case (state)
      IDLE, RESP: begin
        nxt = IDLE;
        if (setup_hit) begin
          cap_en = 1'b1;
          cnt_n  = WC;
          nxt    = (WC == 4'd0) ? RESP : SETUP;
        end
      end
      SETUP, WAIT: begin
        if (!psel) begin
          nxt = IDLE;
        end else if (penable) begin
          cnt_n = cnt - 4'd1;
          nxt   = (cnt == 4'd1) ? RESP : WAIT;
        end
      end
    endcase
  end

  // Zero-wait responses are decided in the setup cycle itself,
  // before the capture registers have loaded.
  assign e_addr  = cap_en ? paddr : cap_addr;
  assign e_wr    = cap_en ? pwrite : cap_wr;
  assign rd_val  = (e_addr == TOP) ? ID_VAL : regs[e_addr];
  assign to_resp = (nxt == RESP);

  assign commit = (state == RESP) & psel & penable
                & cap_wr & (cap_addr != TOP);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state    <= IDLE;
      cnt      <= '0;
      cap_addr <= '0;
      cap_wr   <= 1'b0;
      cap_data <= '0;
      pready   <= 1'b0;
      prdata   <= '0;
      pslverr  <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= cnt_n;
      if (cap_en) begin
        cap_addr <= paddr;
        cap_wr   <= pwrite;
        cap_data <= pwdata;
      end
      pready  <= to_resp;
      prdata  <= (to_resp & ~e_wr) ? rd_val : '0;
      pslverr <= to_resp & e_wr & (e_addr == TOP);
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (commit) begin
      regs[cap_addr] <= cap_data;
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: three instances with 1, 0 and 3 wait states.
// Vector table on the 1-wait instance, then hand-written corner sequences.
module tb_apb_slave_regfile;

  logic        clk;
  logic        presetn;
  logic [2:0]  psel;
  logic        penable;
  logic [3:0]  paddr;
  logic        pwrite;
  logic [15:0] pwdata;
  logic [2:0]  pready;
  logic [15:0] prdata [3];
  logic [2:0]  pslverr;

  int total;
  int passed;

  apb_slave_regfile #(.WAIT_CYCLES(1)) u_w1 (
    .pclk(clk), .presetn(presetn), .psel(psel[0]),
    .penable(penable), .paddr(paddr), .pwrite(pwrite),
    .pwdata(pwdata), .pready(pready[0]), .prdata(prdata[0]),
    .pslverr(pslverr[0])
  );

  apb_slave_regfile #(.WAIT_CYCLES(0)) u_w0 (
    .pclk(clk), .presetn(presetn), .psel(psel[1]),
    .penable(penable), .paddr(paddr), .pwrite(pwrite),
    .pwdata(pwdata), .pready(pready[1]), .prdata(prdata[1]),
    .pslverr(pslverr[1])
  );

  apb_slave_regfile #(.WAIT_CYCLES(3)) u_w3 (
    .pclk(clk), .presetn(presetn), .psel(psel[2]),
    .penable(penable), .paddr(paddr), .pwrite(pwrite),
    .pwdata(pwdata), .pready(pready[2]), .prdata(prdata[2]),
    .pslverr(pslverr[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [3:0]  a;
    logic [15:0] wd;
    logic        scr;
    logic [15:0] rd;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Setup cycle, then access cycles until pready (bounded).
  // Returns with the bus still in the completing access cycle.
  task automatic xfer(input int d, input logic wr,
                      input logic [3:0] a, input logic [15:0] wd,
                      input logic scr, output int lat,
                      output logic [15:0] rd, output logic err);
    lat = -1;
    rd  = '0;
    err = 1'b0;
    @(negedge clk);
    psel    = '0;
    psel[d] = 1'b1;
    penable = 1'b0;
    paddr   = a;
    pwrite  = wr;
    pwdata  = wd;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      penable = 1'b1;
      if (scr) begin
        paddr  = a ^ 4'h1;
        pwdata = ~wd;
      end
      if (pready[d]) begin
        lat = k;
        rd  = prdata[d];
        err = pslverr[d];
        break;
      end
    end
  endtask

  task automatic idle(input int d);
    @(negedge clk);
    psel    = '0;
    penable = 1'b0;
    chk("pready_one_cycle", 32'(pready[d]), 32'd0);
  endtask

  task automatic rd_chk(input int d, input logic [3:0] a,
                        input logic [15:0] exp, input int elat,
                        input string nm);
    int          lat;
    logic [15:0] rd;
    logic        err;
    xfer(d, 1'b0, a, 16'h0, 1'b0, lat, rd, err);
    chk({nm, "_lat"}, 32'(lat), 32'(elat));
    chk({nm, "_data"}, 32'(rd), 32'(exp));
    chk({nm, "_err"}, 32'(err), 32'd0);
    idle(d);
  endtask

  task automatic wr_chk(input int d, input logic [3:0] a,
                        input logic [15:0] wd, input logic scr,
                        input logic eerr, input int elat,
                        input string nm);
    int          lat;
    logic [15:0] rd;
    logic        err;
    xfer(d, 1'b1, a, wd, scr, lat, rd, err);
    chk({nm, "_lat"}, 32'(lat), 32'(elat));
    chk({nm, "_err"}, 32'(err), 32'(eerr));
    idle(d);
  endtask

  initial begin
    int          lat;
    logic [15:0] rd;
    logic        err;

    total   = 0;
    passed  = 0;
    presetn = 1'b1;
    psel    = '0;
    penable = 1'b0;
    paddr   = '0;
    pwrite  = 1'b0;
    pwdata  = '0;

    vt[0]  = '{1'b0, 4'd3,  16'h0000, 1'b0, 16'h0000, 1'b0, 2};
    vt[1]  = '{1'b1, 4'd5,  16'h1234, 1'b0, 16'h0000, 1'b0, 2};
    vt[2]  = '{1'b0, 4'd5,  16'h0000, 1'b0, 16'h1234, 1'b0, 2};
    vt[3]  = '{1'b0, 4'd4,  16'h0000, 1'b0, 16'h0000, 1'b0, 2};
    vt[4]  = '{1'b1, 4'd15, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 2};
    vt[5]  = '{1'b0, 4'd15, 16'h0000, 1'b0, 16'hA5C3, 1'b0, 2};
    vt[6]  = '{1'b1, 4'd7,  16'h0F0F, 1'b1, 16'h0000, 1'b0, 2};
    vt[7]  = '{1'b0, 4'd7,  16'h0000, 1'b0, 16'h0F0F, 1'b0, 2};
    vt[8]  = '{1'b0, 4'd6,  16'h0000, 1'b0, 16'h0000, 1'b0, 2};
    vt[9]  = '{1'b1, 4'd0,  16'h8001, 1'b0, 16'h0000, 1'b0, 2};
    vt[10] = '{1'b0, 4'd0,  16'h0000, 1'b0, 16'h8001, 1'b0, 2};
    vt[11] = '{1'b0, 4'd5,  16'h0000, 1'b0, 16'h1234, 1'b0, 2};

    #1 presetn = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("reset_pready", 32'(pready[d]), 32'd0);
      chk("reset_prdata", 32'(prdata[d]), 32'd0);
      chk("reset_pslverr", 32'(pslverr[d]), 32'd0);
    end
    presetn = 1'b1;

    for (int i = 0; i < 12; i++) begin
      xfer(0, vt[i].wr, vt[i].a, vt[i].wd, vt[i].scr, lat, rd, err);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(vt[i].err));
      if (!vt[i].wr)
        chk($sformatf("vec%0d_data", i), 32'(rd), 32'(vt[i].rd));
      idle(0);
    end

    // Back-to-back write then read, no bus idle between them.
    xfer(0, 1'b1, 4'd1, 16'h00AA, 1'b0, lat, rd, err);
    chk("b2b_wr_lat", 32'(lat), 32'd2);
    chk("b2b_wr_err", 32'(err), 32'd0);
    xfer(0, 1'b0, 4'd1, 16'h0000, 1'b0, lat, rd, err);
    chk("b2b_rd_lat", 32'(lat), 32'd2);
    chk("b2b_rd_data", 32'(rd), 32'h00AA);
    idle(0);

    // Wait-state sweep; pwdata/paddr scrambled during access.
    wr_chk(1, 4'd9, 16'h5A5A, 1'b1, 1'b0, 1, "w0_wr");
    rd_chk(1, 4'd9, 16'h5A5A, 1, "w0_rd");
    rd_chk(1, 4'd8, 16'h0000, 1, "w0_rd8");
    wr_chk(2, 4'd9, 16'h3C3C, 1'b1, 1'b0, 4, "w3_wr");
    rd_chk(2, 4'd9, 16'h3C3C, 4, "w3_rd");
    rd_chk(2, 4'd8, 16'h0000, 4, "w3_rd8");
    wr_chk(2, 4'd15, 16'h1111, 1'b0, 1'b1, 4, "w3_wr_id");
    rd_chk(2, 4'd15, 16'hA5C3, 4, "w3_rd_id");

    // Abort: psel drops while the 3-wait instance is in WAIT.
    @(negedge clk);
    psel    = 3'b100;
    penable = 1'b0;
    paddr   = 4'd2;
    pwrite  = 1'b1;
    pwdata  = 16'hBEEF;
    @(negedge clk);
    penable = 1'b1;
    chk("abort_acc1_pready", 32'(pready[2]), 32'd0);
    @(negedge clk);
    chk("abort_acc2_pready", 32'(pready[2]), 32'd0);
    psel    = '0;
    penable = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_after_pready", 32'(pready[2]), 32'd0);
    rd_chk(2, 4'd2, 16'h0000, 4, "abort_rd2");

    // Reset while the 1-wait instance is in RESP and 3-wait is in WAIT.
    @(negedge clk);
    psel    = 3'b101;
    penable = 1'b0;
    paddr   = 4'd15;
    pwrite  = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    chk("pre_rst_pready", 32'(pready[0]), 32'd1);
    chk("pre_rst_prdata", 32'(prdata[0]), 32'hA5C3);
    presetn = 1'b0;
    #1;
    chk("rst_pready", 32'(pready[0]), 32'd0);
    chk("rst_prdata", 32'(prdata[0]), 32'd0);
    chk("rst_pslverr", 32'(pslverr[0]), 32'd0);
    chk("rst_w3_pready", 32'(pready[2]), 32'd0);
    psel    = '0;
    penable = 1'b0;
    repeat (2) @(negedge clk);
    presetn = 1'b1;

    for (int a = 0; a < 15; a++) begin
      rd_chk(0, 4'(a), 16'h0000, 2, $sformatf("clr_w1_%0d", a));
      rd_chk(2, 4'(a), 16'h0000, 4, $sformatf("clr_w3_%0d", a));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
